wb_cmd_master: RTL and testbench

//  Wishbone classic single-transfer bus initiator (master) driving peripherals like wb_misc.

---
 rtl/wb_cmd_master_pkg.sv | 13 +
 rtl/wb_cmd_master_watchdog.sv | 28 ++
 rtl/wb_cmd_master.sv | 130 +++++++++++++
 tb/tb_wb_cmd_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master: FSM state encoding and default bus widths.
package wb_cmd_master_pkg;

  localparam int unsigned WB_DEF_AW = 32;
  localparam int unsigned WB_DEF_DW = 32;

  typedef enum logic [1:0] {
    WB_ST_IDLE = 2'd0,
    WB_ST_BUS  = 2'd1,
    WB_ST_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_cmd_master_watchdog.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_cnt == CW'(TIMEOUT - 1));
  assign o_expired  = i_en && w_at_limit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command/response stream.
// Optional bus timeout is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned AW      = WB_DEF_AW,
  parameter int unsigned DW      = WB_DEF_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  output logic            busy_o
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT must be at least 2");
  end
  if ((DW % 8) != 0) begin : g_bad_dw
    $error("wb_cmd_master: DW must be a multiple of 8");
  end

  wb_state_e       r_state;
  logic [AW-1:0]   r_adr;
  logic [DW-1:0]   r_dat;
  logic [DW/8-1:0] r_sel;
  logic            r_we;
  logic            r_cyc;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_dat;
  logic            r_rsp_err;
  logic            w_accept;
  logic            w_expired;

  assign cmd_ready_o = (r_state == WB_ST_IDLE) && wb_reset_n_i;
  assign w_accept    = cmd_valid_i && cmd_ready_o;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_reset_n_i),
    .i_clr     (w_accept),
    .i_en      ((r_state == WB_ST_BUS) && !wb_ack_i),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Ack is tested before expiry so an ack in the final allowed cycle completes normally.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_reset_n_i) begin
      r_state     <= WB_ST_IDLE;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        WB_ST_IDLE: begin
          if (w_accept) begin
            r_adr   <= cmd_adr_i;
            r_dat   <= cmd_dat_i;
            r_sel   <= cmd_sel_i;
            r_we    <= cmd_we_i;
            r_cyc   <= 1'b1;
            r_state <= WB_ST_BUS;
          end
        end
        WB_ST_BUS: begin
          if (wb_ack_i) begin
            r_cyc       <= 1'b0;
            r_rsp_dat   <= r_we ? '0 : wb_dat_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= WB_ST_RESP;
          end else if (w_expired) begin
            r_cyc       <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= WB_ST_RESP;
          end
        end
        WB_ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= WB_ST_IDLE;
          end
        end
        default: r_state <= WB_ST_IDLE;
      endcase
    end
  end

  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_dat;
  assign wb_sel_o    = r_sel;
  assign wb_we_o     = r_we;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign busy_o      = (r_state != WB_ST_IDLE);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master with a latency-programmable Wishbone responder.
module tb_wb_cmd_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, busy;
  logic [3:0]  wb_sel;

  logic        ack_resp, ack_stray;
  int          ack_lat;
  int          rcnt;
  int          n_tests, n_fail;
  int          n_stb, n_lat;
  logic [31:0] hold_dat;

  wb_cmd_master #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (8)
  ) dut (
    .wb_clk_i     (clk),
    .wb_reset_n_i (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_we_i     (cmd_we),
    .cmd_adr_i    (cmd_adr),
    .cmd_dat_i    (cmd_dat),
    .cmd_sel_i    (cmd_sel),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dat_o    (rsp_dat),
    .rsp_err_o    (rsp_err),
    .wb_adr_o     (wb_adr),
    .wb_dat_o     (wb_dat_o),
    .wb_we_o      (wb_we),
    .wb_sel_o     (wb_sel),
    .wb_cyc_o     (wb_cyc),
    .wb_stb_o     (wb_stb),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign wb_ack = ack_resp | ack_stray;

  // Responder: ack is registered ack_lat edges after stb first seen; ack_lat==0 never acks.
  always @(posedge clk) begin
    if (wb_cyc && wb_stb && !ack_resp && ack_lat != 0) begin
      rcnt = rcnt + 1;
      if (rcnt == ack_lat) ack_resp <= 1'b1;
    end else begin
      rcnt = 0;
      ack_resp <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int budget,
                         output int o_stb, output int o_lat);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    o_stb = 0;
    o_lat = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("req_adr", wb_adr, adr);
        chk("req_dat", wb_dat_o, dat);
        chk("req_sel", wb_sel, sel);
        chk("req_we", wb_we, we);
        chk("req_cyc", wb_cyc, 1'b1);
        chk("bus_cmd_ready", cmd_ready, 1'b0);
        chk("bus_busy", busy, 1'b1);
      end
      if (wb_stb) o_stb++;
      if (rsp_valid) begin
        o_lat = n;
        break;
      end
    end
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", wb_cyc, 1'b0);
    chk("rst_stb", wb_stb, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_dat_i = '0; ack_resp = 1'b0; ack_stray = 1'b0; ack_lat = 1; rcnt = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cyc", wb_cyc, 1'b0);
    chk("reset_stb", wb_stb, 1'b0);
    chk("reset_we", wb_we, 1'b0);
    chk("reset_adr", wb_adr, 32'h0);
    chk("reset_dat", wb_dat_o, 32'h0);
    chk("reset_sel", wb_sel, 4'h0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_dat", rsp_dat, 32'h0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1'b1);

    // 1: write with one-cycle responder
    ack_lat = 1; wb_dat_i = 32'h5555_AAAA;
    run_txn(1'b1, 32'h0, 32'h0000_00AB, 4'h1, 50, n_stb, n_lat);
    chk("t1_stb_cycles", n_stb, 2);
    chk("t1_rsp_lat", n_lat, 3);
    chk("t1_rsp_dat", rsp_dat, 32'h0);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_stb_low", wb_stb, 1'b0);
    finish_rsp();

    // 2: read
    wb_dat_i = 32'hFFFF_FF80;
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 50, n_stb, n_lat);
    chk("t2_stb_cycles", n_stb, 2);
    chk("t2_rsp_lat", n_lat, 3);
    chk("t2_rsp_dat", rsp_dat, 32'hFFFF_FF80);
    chk("t2_rsp_err", rsp_err, 1'b0);
    finish_rsp();

    // 3: response back-pressure for 5 cycles
    wb_dat_i = 32'h1234_5678;
    run_txn(1'b0, 32'h0000_0004, 32'h0, 4'hF, 50, n_stb, n_lat);
    chk("t3_rsp_lat", n_lat, 3);
    hold_dat = 32'h1234_5678;
    wb_dat_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", rsp_valid, 1'b1);
      chk("t3_hold_dat", rsp_dat, hold_dat);
      chk("t3_hold_err", rsp_err, 1'b0);
      chk("t3_hold_cmd_ready", cmd_ready, 1'b0);
      chk("t3_hold_cyc", wb_cyc, 1'b0);
    end
    finish_rsp();

    // 4: responder never acks
    ack_lat = 0; wb_dat_i = 32'h7777_7777;
`ifdef WB_MASTER_TIMEOUT_EN
    run_txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 50, n_stb, n_lat);
    chk("t4_stb_cycles", n_stb, 8);
    chk("t4_rsp_lat", n_lat, 9);
    chk("t4_rsp_err", rsp_err, 1'b1);
    chk("t4_rsp_dat", rsp_dat, 32'h0);
    chk("t4_stb_low", wb_stb, 1'b0);
    finish_rsp();
`else
    run_txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 100, n_stb, n_lat);
    chk("t4_stb_cycles", n_stb, 100);
    chk("t4_no_rsp", n_lat, 0);
    chk("t4_stb_still_high", wb_stb, 1'b1);
    pulse_reset();
    @(negedge clk);
    chk("t4_recover_cmd_ready", cmd_ready, 1'b1);
`endif

    // 5: reset asserted during the second bus cycle
    ack_lat = 1; wb_dat_i = 32'h0BAD_0BAD;
    @(negedge clk);
    cmd_we = 1'b0; cmd_adr = 32'h0000_0030; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_bus_stb", wb_stb, 1'b1);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 1'b0);
      chk("t5_cmd_ready", cmd_ready, 1'b1);
      chk("t5_busy", busy, 1'b0);
    end

    // 6: ack first sampled in the 8th stb cycle
    ack_lat = 7; wb_dat_i = 32'hCAFE_0006;
    run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h3, 50, n_stb, n_lat);
    chk("t6_stb_cycles", n_stb, 8);
    chk("t6_rsp_lat", n_lat, 9);
    chk("t6_rsp_err", rsp_err, 1'b0);
    chk("t6_rsp_dat", rsp_dat, 32'hCAFE_0006);
    finish_rsp();

    // Stray ack while idle
    @(negedge clk);
    ack_stray = 1'b1;
    @(negedge clk);
    ack_stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_no_rsp", rsp_valid, 1'b0);
      chk("stray_busy", busy, 1'b0);
    end

    // Normal write still works afterwards
    ack_lat = 1;
    run_txn(1'b1, 32'h0000_0044, 32'h0102_0304, 4'hC, 50, n_stb, n_lat);
    chk("t7_stb_cycles", n_stb, 2);
    chk("t7_rsp_dat", rsp_dat, 32'h0);
    finish_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
